irq_ctrl: RTL

//  Interrupt controller that sits in front of CP0 and drives its HWInt[7:2] inputs.

---
 rtl/irq_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// Interrupt controller feeding CP0 HWInt[7:2]: per-source level/edge capture,
// enable masking, fixed priority with in-service nesting, claim-by-read / complete-by-write.
module irq_ctrl #(
  parameter int NUM_SRC = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [1:0]         addr,
  input  logic               we,
  input  logic               re,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic [NUM_SRC-1:0] hwint,
  output logic               any_req
);

  typedef logic [NUM_SRC-1:0] vec_t;

  localparam logic [1:0] A_PEND  = 2'd0;
  localparam logic [1:0] A_EN    = 2'd1;
  localparam logic [1:0] A_MODE  = 2'd2;
  localparam logic [1:0] A_CLAIM = 2'd3;
  localparam logic [3:0] NUM_SRC_W = 4'(NUM_SRC);

  vec_t samp_q, samp_d;
  vec_t prev_q, prev_d;
  vec_t edge_pend_q, edge_pend_d;
  vec_t en_q, en_d;
  vec_t mode_q, mode_d;
  vec_t isr_q, isr_d;

  vec_t       rise;
  vec_t       pend;
  vec_t       blocked;
  vec_t       eligible;
  logic       claim_valid;
  logic [2:0] claim_idx;

  // Bus strobes carry no handshake: every access completes in the cycle it is
  // presented. A write wins over a simultaneous read, so a claim only fires on
  // a read-only cycle that addresses CLAIM while a source is eligible.
  logic bus_wr;
  logic claim_fire;
  logic cpl_fire;
  vec_t claim_onehot;
  vec_t cpl_onehot;
  vec_t w1c_mask;
  vec_t mode_chg;

  logic unused_wdata;
  assign unused_wdata = ^wdata[31:NUM_SRC];

  assign rise = samp_q & ~prev_q;
  assign pend = (mode_q & edge_pend_q) | (~mode_q & samp_q);

  // blocked[i] is set when any source of equal or higher priority is in service.
  always_comb begin
    logic acc;
    acc     = 1'b0;
    blocked = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      acc        = acc | isr_q[i];
      blocked[i] = acc;
    end
  end

  assign eligible = pend & en_q & ~blocked;
  assign hwint    = eligible;
  assign any_req  = |eligible;

  always_comb begin
    claim_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        claim_idx = 3'(i);
      end
    end
  end

  assign claim_valid = |eligible;

  assign bus_wr       = we;
  assign claim_fire   = re && !we && (addr == A_CLAIM) && claim_valid;
  assign cpl_fire     = bus_wr && (addr == A_CLAIM) && ({1'b0, wdata[2:0]} < NUM_SRC_W);
  assign claim_onehot = claim_fire ? (vec_t'(1) << claim_idx) : '0;
  assign cpl_onehot   = cpl_fire ? (vec_t'(1) << wdata[2:0]) : '0;
  assign w1c_mask     = (bus_wr && (addr == A_PEND)) ? (wdata[NUM_SRC-1:0] & mode_q) : '0;

  always_comb begin
    samp_d = irq_in;
    prev_d = samp_q;
    en_d   = en_q;
    mode_d = mode_q;
    if (bus_wr && (addr == A_EN)) begin
      en_d = wdata[NUM_SRC-1:0];
    end
    if (bus_wr && (addr == A_MODE)) begin
      mode_d = wdata[NUM_SRC-1:0];
    end
  end

  assign mode_chg = mode_d ^ mode_q;

  // A fresh rise outranks W1C and claim; a MODE flip discards the edge latch.
  always_comb begin
    edge_pend_d = mode_q & ~mode_chg &
                  ((edge_pend_q & ~w1c_mask & ~claim_onehot) | rise);
    isr_d       = (isr_q & ~cpl_onehot) | claim_onehot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q      <= '0;
      prev_q      <= '0;
      edge_pend_q <= '0;
      en_q        <= '0;
      mode_q      <= '0;
      isr_q       <= '0;
    end else begin
      samp_q      <= samp_d;
      prev_q      <= prev_d;
      edge_pend_q <= edge_pend_d;
      en_q        <= en_d;
      mode_q      <= mode_d;
      isr_q       <= isr_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      A_PEND:  rdata = {{(32-NUM_SRC){1'b0}}, pend};
      A_EN:    rdata = {{(32-NUM_SRC){1'b0}}, en_q};
      A_MODE:  rdata = {{(32-NUM_SRC){1'b0}}, mode_q};
      A_CLAIM: rdata = {claim_valid, 28'b0, claim_idx};
      default: rdata = '0;
    endcase
  end

endmodule
